// File: rtl/dac_feed_ctrl.sv
// dac_feed_ctrl: sample-rate scheduler and pop-free mute controller feeding the delta-sigma DAC
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   s_data/s_valid     excess-2^(N-1) samples from the mixer
//   s_ready            FIFO can accept (not full and not flushing)
//   enable             1 = play, 0 = ramp to midscale and mute
//   flush              synchronous FIFO clear
//   dac_in             registered DAC input word
//   sample_tick        one-cycle pulse per sample period
//   state              0=MUTED, 1=RUN, 2=RAMP
//   fifo_level         current FIFO occupancy
//   underflow          one-cycle pulse on an empty pop in RUN
//   underflow_count    saturating underflow count
module dac_feed_ctrl #(
    parameter int N          = 8,
    parameter int DIV        = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_STEP  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N-1:0]                  s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          enable,
    input  logic                          flush,
    output logic [N-1:0]                  dac_in,
    output logic                          sample_tick,
    output logic [1:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic [7:0]                    underflow_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {MUTED = 2'd0, RUN = 2'd1, RAMP = 2'd2} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [AW:0]    r_level;
    logic [N-1:0]   r_dac, w_dac_nxt, w_ramp;
    logic [N:0]     w_up, w_dn;
    logic [7:0]     r_ufc;
    logic           r_uf, w_uf, w_tick, w_full, w_push, w_pop, w_pop_req;

    assign w_tick  = r_cnt == CW'(DIV - 1);
    assign w_full  = r_level == (AW+1)'(FIFO_DEPTH);
    assign s_ready = !w_full && !flush;
    assign w_push  = s_valid && s_ready;
    // flush wins over any FSM pop in the same cycle
    assign w_pop   = w_pop_req && !flush;

    // one ramp step toward midscale in N+1 bits, clamped so it never crosses midscale
    assign w_up   = {1'b0, r_dac} + (N+1)'(RAMP_STEP);
    assign w_dn   = {1'b0, r_dac} - (N+1)'(RAMP_STEP);
    assign w_ramp = (r_dac < MID) ? ((w_up >= {1'b0, MID}) ? MID : w_up[N-1:0])
                                  : ((w_dn <= {1'b0, MID}) ? MID : w_dn[N-1:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_dac_nxt   = r_dac;
        w_pop_req   = 1'b0;
        w_uf        = 1'b0;
        if (w_tick) begin
            case (r_state)
                MUTED: if (enable && r_level >= (AW+1)'(FIFO_DEPTH / 2)) begin
                    w_pop_req   = 1'b1;
                    w_dac_nxt   = r_mem[r_rptr];
                    w_state_nxt = RUN;
                end
                RUN: if (!enable) begin
                    w_dac_nxt   = w_ramp;
                    w_state_nxt = (w_ramp == MID) ? MUTED : RAMP;
                end else if (r_level != '0) begin
                    w_pop_req = 1'b1;
                    w_dac_nxt = r_mem[r_rptr];
                end else begin
                    w_uf = 1'b1;
                end
                RAMP: begin
                    w_dac_nxt   = w_ramp;
                    w_state_nxt = (w_ramp == MID) ? MUTED : RAMP;
                end
                default: w_state_nxt = MUTED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_state <= MUTED;
            r_dac   <= MID;
            r_uf    <= 1'b0;
            r_ufc   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_state <= w_state_nxt;
            r_dac   <= w_dac_nxt;
            r_uf    <= w_uf;
            if (w_uf && r_ufc != 8'hFF)
                r_ufc <= r_ufc + 8'd1;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
                r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= s_data;
    end

    assign dac_in          = r_dac;
    assign sample_tick     = w_tick;
    assign state           = r_state;
    assign fifo_level      = r_level;
    assign underflow       = r_uf;
    assign underflow_count = r_ufc;
endmodule

// File: tb/tb_dac_feed_ctrl.sv
// tb_dac_feed_ctrl: randomized scoreboard bench for dac_feed_ctrl against a queue-based reference model
module tb_dac_feed_ctrl;
    localparam int N = 8, DIV = 4, DEPTH = 4, STEP = 16, MID = 128;

    logic       clk = 1'b0, reset = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0, enable = 1'b0, flush = 1'b0;
    logic       s_ready, sample_tick, underflow;
    logic [7:0] dac_in, underflow_count;
    logic [1:0] state;
    logic [2:0] fifo_level;

    dac_feed_ctrl #(.N(N), .DIV(DIV), .FIFO_DEPTH(DEPTH), .RAMP_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .enable(enable), .flush(flush), .dac_in(dac_in), .sample_tick(sample_tick),
        .state(state), .fifo_level(fifo_level), .underflow(underflow),
        .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    typedef struct {int dac; int st; int lvl; int rdy; int tk; int uf; int ufc;} rec_t;
    rec_t exq[$];
    int   fq[$];
    int   m_dac, m_st, m_cnt, m_ufc, m_uf;
    int   n_vec = 0, n_err = 0;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int toward_mid(int d);
        if (d < MID) return (d + STEP > MID) ? MID : d + STEP;
        return (d - STEP < MID) ? MID : d - STEP;
    endfunction

    function automatic void model_reset();
        fq.delete();
        exq.delete();
        m_dac = MID; m_st = 0; m_cnt = 0; m_ufc = 0; m_uf = 0;
    endfunction

    // drive one cycle's inputs (called at a negedge), predict the next edge, queue the expectation
    task automatic cyc(input bit v, input int d, input bit en, input bit fl);
        bit tk, rdy, pop;
        s_valid = v; s_data = 8'(d); enable = en; flush = fl;
        tk  = (m_cnt == DIV - 1);
        rdy = (fq.size() < DEPTH) && !fl;
        pop = 1'b0;
        m_uf = 0;
        if (tk) begin
            if (m_st == 0) begin
                if (en && fq.size() >= DEPTH / 2) begin m_dac = fq[0]; pop = 1'b1; m_st = 1; end
            end else if (m_st == 1 && en) begin
                if (fq.size() > 0) begin m_dac = fq[0]; pop = 1'b1; end
                else begin m_uf = 1; m_ufc = (m_ufc == 255) ? 255 : m_ufc + 1; end
            end else begin
                m_dac = toward_mid(m_dac);
                m_st  = (m_dac == MID) ? 0 : 2;
            end
        end
        if (fl) fq.delete();
        else begin
            if (pop) void'(fq.pop_front());
            if (v && rdy) fq.push_back(d & 8'hFF);
        end
        m_cnt = tk ? 0 : m_cnt + 1;
        exq.push_back('{m_dac, m_st, fq.size(), ((fq.size() < DEPTH) && !fl) ? 1 : 0,
                        (m_cnt == DIV - 1) ? 1 : 0, m_uf, m_ufc});
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_dac", int'(dac_in), MID);
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'(s_ready), 1);
        chk("rst_ufc", int'(underflow_count), 0);
        chk("rst_uf", int'(underflow), 0);
        chk("rst_tick", int'(sample_tick), 0);
    endtask

    // reset asserted between clock edges must act immediately
    task automatic do_reset();
        s_valid = 1'b0; flush = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_vals();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exq.size() > 0) begin
                r = exq.pop_front();
                chk("dac_in", int'(dac_in), r.dac);
                chk("state", int'(state), r.st);
                chk("fifo_level", int'(fifo_level), r.lvl);
                chk("s_ready", int'(s_ready), r.rdy);
                chk("sample_tick", int'(sample_tick), r.tk);
                chk("underflow", int'(underflow), r.uf);
                chk("underflow_count", int'(underflow_count), r.ufc);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int guard;
        bit en;
        model_reset();
        #1 reset = 1'b1;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // start playing from two buffered samples, then drain into underflow
        cyc(1, 'h10, 1, 0);
        cyc(1, 'h20, 1, 0);
        repeat (1250) cyc(0, 0, 1, 0);
        // mute ramp from the held word
        repeat (32) cyc(0, 0, 0, 0);
        // fill while muted, overrun, then flush with a coincident push
        cyc(1, 'hA0, 0, 0);
        cyc(1, 'hB0, 0, 0);
        cyc(1, 'hC0, 0, 0);
        cyc(1, 'hD0, 0, 0);
        cyc(1, 'hEE, 0, 0);
        cyc(1, 'hEF, 0, 0);
        cyc(1, 'h55, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
        // start playing, then reset between ticks once running
        cyc(1, 'h10, 1, 0);
        cyc(1, 'h20, 1, 0);
        guard = 0;
        while (m_st != 1 && guard < 20) begin
            cyc(0, 0, 1, 0);
            guard++;
        end
        chk("reach_run", m_st, 1);
        do_reset();
        // randomized play/mute/flush traffic with occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            en = ($urandom_range(0, 3) != 0);
            repeat (80)
                cyc($urandom_range(0, 9) < 3, int'($urandom_range(0, 255)), en,
                    $urandom_range(0, 59) == 0);
            if (seg % 15 == 14) do_reset();
        end
        repeat (4) cyc(0, 0, 0, 0);
        chk("scoreboard_drain", exq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
